spi_master_ctrl: RTL and testbench

- Initiator end of the board SPI link; drives the SPI slave FSM/memory block.
- One request = one 16-bit frame, MSB first: A6..A0, RW (1=read, 0=write), then D7..D0.
- Generates CS, SCLK and MOSI in SPI mode 0 (CPOL=0, CPHA=0) and captures MISO for reads.
- Host side is a start/busy/done handshake.

---
 rtl/spi_master_ctrl.sv | 175 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: one 16-bit frame {addr[6:0], rw, data[7:0]} per start, MSB first.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds mosi back into the read capture.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic       loopback
`endif
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  gap_q, gap_d;
  logic [14:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        div_last;
  logic        cap_bit;

  always_comb begin
`ifdef SPI_MASTER_LOOPBACK_EN
    cap_bit = loopback ? mosi_q : miso;
`else
    cap_bit = miso;
`endif
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rw_d     = rw_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    div_last = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          div_d   = '0;
          bit_d   = '0;
          // Read frames carry zeros in the data slot so mosi stays low there.
          tx_d    = {addr[5:0], rw, rw ? 8'h00 : wdata};
          rx_d    = '0;
          rw_d    = rw;
          cs_n_d  = 1'b0;
          mosi_d  = addr[6];
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            bit_d  = bit_q + 5'd1;
            mosi_d = tx_q[14];
            tx_d   = {tx_q[13:0], 1'b0};
            if (bit_q == 5'd15) state_d = HOLD;
          end else if (rw_q && bit_q[3]) begin
            rx_d = {rx_q[6:0], cap_bit};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_last) begin
          div_d   = '0;
          gap_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = GAP;
          if (rw_q) rdata_d = rx_q;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign cs_n  = cs_n_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three DUT lanes (CLK_DIV/CS_GAP = 4/2, 2/3, 1/0) checked against a frame-timeline model.
// Connects and exercises the loopback port when SPI_MASTER_LOOPBACK_EN is defined.
module tb_spi_master_ctrl;

  localparam int NL = 3;
  localparam int DV [NL] = '{4, 2, 1};
  localparam int GP [NL] = '{2, 3, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s [NL];
  logic       start_s [NL];
  logic       rw_s    [NL];
  logic [6:0] addr_s  [NL];
  logic [7:0] wdata_s [NL];
  logic       miso_s  [NL];
  logic       lb_s    [NL];
  logic [7:0] rdata_s [NL];
  logic       busy_s  [NL];
  logic       done_s  [NL];
  logic       cs_n_s  [NL];
  logic       sclk_s  [NL];
  logic       mosi_s  [NL];

  logic [7:0] sbyte_s [NL];
  logic       tie1_s  [NL];

  // Model: cycle n counts clk edges since the accepting edge.
  logic        m_act   [NL];
  int          m_n     [NL];
  logic [15:0] m_frame [NL];
  logic        m_rw    [NL];
  logic [7:0]  m_cap   [NL];
  logic [7:0]  m_rdata [NL];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < NL; g++) begin : lane
    spi_master_ctrl #(.CLK_DIV(DV[g]), .CS_GAP(GP[g])) u_dut (
      .clk     (clk),
      .rst_n   (rst_n_s[g]),
      .start   (start_s[g]),
      .rw      (rw_s[g]),
      .addr    (addr_s[g]),
      .wdata   (wdata_s[g]),
      .rdata   (rdata_s[g]),
      .busy    (busy_s[g]),
      .done    (done_s[g]),
      .cs_n    (cs_n_s[g]),
      .sclk    (sclk_s[g]),
      .mosi    (mosi_s[g]),
      .miso    (miso_s[g])
`ifdef SPI_MASTER_LOOPBACK_EN
      ,
      .loopback(lb_s[g])
`endif
    );
  end

  task automatic check(input string name, input int l, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, l, got, want, $time);
    end
  endtask

  function automatic logic exp_mosi(input int l);
    int b;
    if (!m_act[l] || m_n[l] >= 33 * DV[l]) return 1'b0;
    b = m_n[l] / (2 * DV[l]);
    if (b > 15) return 1'b0;
    return m_frame[l][15 - b];
  endfunction

  function automatic logic exp_sclk(input int l);
    if (!m_act[l] || m_n[l] < DV[l] || m_n[l] >= 32 * DV[l]) return 1'b0;
    return ((m_n[l] / DV[l]) % 2) == 1;
  endfunction

  function automatic logic exp_cs_n(input int l);
    return !(m_act[l] && m_n[l] < 33 * DV[l]);
  endfunction

  function automatic logic exp_done(input int l);
    return m_act[l] && m_n[l] == 33 * DV[l];
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (!rst_n_s[l]) begin
        m_act[l]   = 1'b0;
        m_rdata[l] = '0;
      end else if (m_act[l]) begin
        if (m_rw[l] && (m_n[l] + 1) >= 17 * DV[l] && (m_n[l] + 1) <= 31 * DV[l] &&
            ((m_n[l] + 1) % (2 * DV[l])) == DV[l])
          m_cap[l] = {m_cap[l][6:0], lb_s[l] ? exp_mosi(l) : miso_s[l]};
        m_n[l]++;
        if (m_n[l] == 33 * DV[l] && m_rw[l]) m_rdata[l] = m_cap[l];
        if (m_n[l] == 33 * DV[l] + GP[l] + 1) m_act[l] = 1'b0;
      end else if (start_s[l]) begin
        m_act[l]   = 1'b1;
        m_n[l]     = 0;
        m_rw[l]    = rw_s[l];
        m_frame[l] = {addr_s[l], rw_s[l], rw_s[l] ? 8'h00 : wdata_s[l]};
        m_cap[l]   = '0;
      end
    end
  end

  // Slave model: presents sbyte MSB first during the data bits of a read, noise elsewhere.
  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (tie1_s[l])
        miso_s[l] = 1'b1;
      else if (m_act[l] && m_rw[l] && m_n[l] / (2 * DV[l]) >= 8 && m_n[l] / (2 * DV[l]) <= 15)
        miso_s[l] = sbyte_s[l][15 - m_n[l] / (2 * DV[l])];
      else
        miso_s[l] = 1'($urandom);
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      check("cs_n",  l, 16'(cs_n_s[l]),  16'(exp_cs_n(l)));
      check("sclk",  l, 16'(sclk_s[l]),  16'(exp_sclk(l)));
      check("mosi",  l, 16'(mosi_s[l]),  16'(exp_mosi(l)));
      check("busy",  l, 16'(busy_s[l]),  16'(m_act[l]));
      check("done",  l, 16'(done_s[l]),  16'(exp_done(l)));
      check("rdata", l, 16'(rdata_s[l]), 16'(m_rdata[l]));
    end
  end

  task automatic assert_reset(input int l);
    #2;
    rst_n_s[l] = 1'b0;
    m_act[l]   = 1'b0;
    m_rdata[l] = '0;
  endtask

  task automatic wait_idle(input int l);
    int t = 0;
    while (busy_s[l] !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", l, 16'(busy_s[l]), 16'd0);
  endtask

  task automatic run_frame(input int l, input logic rw, input logic [6:0] a, input logic [7:0] wd,
                           input logic [7:0] sb, output int rises, output logic [15:0] mbits,
                           output int cs_low, output int toggles, output int dones, output logic [7:0] rd);
    int t = 0;
    logic prev = 1'b0;
    logic seen = 1'b0;
    wait_idle(l);
    @(negedge clk);
    rw_s[l] = rw; addr_s[l] = a; wdata_s[l] = wd; sbyte_s[l] = sb; start_s[l] = 1'b1;
    @(negedge clk);
    start_s[l] = 1'b0;
    rises = 0; mbits = '0; cs_low = 0; toggles = 0; dones = 0; rd = '0;
    while (!seen && t < 40 * DV[l] + 10) begin
      if (cs_n_s[l] == 1'b0) begin
        cs_low++;
        if (sclk_s[l] != prev) toggles++;
      end
      if (sclk_s[l] && !prev) begin
        rises++;
        mbits = {mbits[14:0], mosi_s[l]};
      end
      if (done_s[l]) begin
        dones++;
        rd = rdata_s[l];
        seen = 1'b1;
      end
      prev = sclk_s[l];
      @(negedge clk);
      t++;
    end
    check("frame_end", l, 16'(seen), 16'd1);
    check("done_width", l, 16'(done_s[l]), 16'd0);
  endtask

  task automatic run_lane(input int l);
    int rises, csl, tog, dn, high, blow, t;
    logic [15:0] mb;
    logic [7:0] rd;
    logic second, prev;
    repeat (3) @(negedge clk);
    #2 rst_n_s[l] = 1'b1;

    case (l)
      0: begin
        run_frame(l, 1'b0, 7'h2A, 8'hC3, 8'h00, rises, mb, csl, tog, dn, rd);
        check("wr_rises", l, 16'(rises), 16'd16);
        check("wr_mosi_bits", l, mb, 16'h54C3);
        check("wr_cs_low", l, 16'(csl), 16'd132);
        check("wr_dones", l, 16'(dn), 16'd1);
        check("wr_rdata", l, 16'(rd), 16'h00);
      end
      1: begin
        run_frame(l, 1'b1, 7'h05, 8'hFF, 8'hA5, rises, mb, csl, tog, dn, rd);
        check("rd_rdata", l, 16'(rd), 16'hA5);
        check("rd_model", l, 16'(m_rdata[l]), 16'hA5);
        check("rd_mosi_bits", l, mb, 16'h0B00);
        check("rd_rises", l, 16'(rises), 16'd16);
        // Back-to-back with start held high through the whole first frame.
        wait_idle(l);
        @(negedge clk);
        rw_s[l] = 1'b0; addr_s[l] = 7'h11; wdata_s[l] = 8'h5A; start_s[l] = 1'b1;
        dn = 0; high = 0; blow = 0; second = 1'b0; t = 0;
        while (t < 600) begin
          @(negedge clk);
          t++;
          if (done_s[l]) dn++;
          if (dn == 1 && !second) begin
            if (cs_n_s[l]) high++;
            else begin second = 1'b1; start_s[l] = 1'b0; end
            if (!busy_s[l]) blow++;
          end
          if (dn == 2 && !busy_s[l]) break;
        end
        start_s[l] = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_cs_high", l, 16'(high), 16'd5);
        check("b2b_busy_low", l, 16'(blow), 16'd1);
        check("b2b_frames", l, 16'(dn), 16'd2);
      end
      default: begin
        tie1_s[l] = 1'b1;
        run_frame(l, 1'b1, 7'h3C, 8'h00, 8'hFF, rises, mb, csl, tog, dn, rd);
        check("d1_rdata", l, 16'(rd), 16'hFF);
        check("d1_model", l, 16'(m_rdata[l]), 16'hFF);
        check("d1_toggles", l, 16'(tog), 16'd32);
        check("d1_cs_low", l, 16'(csl), 16'd33);
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_s[l] = 1'b1;
        run_frame(l, 1'b1, 7'h7F, 8'h00, 8'hFF, rises, mb, csl, tog, dn, rd);
        check("lb_rdata", l, 16'(rd), 16'h00);
        check("lb_rises", l, 16'(rises), 16'd16);
        lb_s[l] = 1'b0;
`endif
        tie1_s[l] = 1'b0;
      end
    endcase

    // Reset mid-frame after the fifth SCLK rise.
    wait_idle(l);
    @(negedge clk);
    rw_s[l] = 1'b0; addr_s[l] = 7'h33; wdata_s[l] = 8'h96; start_s[l] = 1'b1;
    @(negedge clk);
    start_s[l] = 1'b0;
    rises = 0; prev = 1'b0; t = 0;
    while (t < 400) begin
      if (sclk_s[l] && !prev) rises++;
      prev = sclk_s[l];
      if (rises == 5) break;
      @(negedge clk);
      t++;
    end
    check("five_rises", l, 16'(rises), 16'd5);
    assert_reset(l);
    #1;
    check("rst_cs_n", l, 16'(cs_n_s[l]), 16'd1);
    check("rst_sclk", l, 16'(sclk_s[l]), 16'd0);
    check("rst_mosi", l, 16'(mosi_s[l]), 16'd0);
    check("rst_busy", l, 16'(busy_s[l]), 16'd0);
    check("rst_done", l, 16'(done_s[l]), 16'd0);
    repeat (2) @(negedge clk);
    #2 rst_n_s[l] = 1'b1;
    run_frame(l, 1'b0, 7'h4E, 8'h1B, 8'h00, rises, mb, csl, tog, dn, rd);
    check("post_rst_dones", l, 16'(dn), 16'd1);
    check("post_rst_bits", l, mb, 16'h9C1B);

    // Randomized traffic: every input re-rolled each cycle, the model decides what is accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) begin
        assert_reset(l);
        @(negedge clk);
        #2 rst_n_s[l] = 1'b1;
      end
      start_s[l] = ($urandom_range(0, 4) == 0);
      rw_s[l]    = 1'($urandom);
      addr_s[l]  = 7'($urandom);
      wdata_s[l] = 8'($urandom);
      if ($urandom_range(0, 15) == 0) sbyte_s[l] = 8'($urandom);
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_s[l] = 1'($urandom);
`endif
    end
    @(negedge clk);
    start_s[l] = 1'b0;
    wait_idle(l);
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      rst_n_s[l] = 1'b0; start_s[l] = 1'b0; rw_s[l] = 1'b0; addr_s[l] = '0; wdata_s[l] = '0;
      lb_s[l] = 1'b0; tie1_s[l] = 1'b0; sbyte_s[l] = '0; miso_s[l] = 1'b0;
      m_act[l] = 1'b0; m_n[l] = 0; m_frame[l] = '0; m_rw[l] = 1'b0; m_cap[l] = '0; m_rdata[l] = '0;
    end
    fork
      run_lane(0);
      run_lane(1);
      run_lane(2);
    join
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
